ps2_byte_receiver: RTL and testbench



---
 rtl/ps2_byte_receiver_if.sv | 31 +++
 rtl/ps2_byte_receiver.sv | 195 +++++++++++++++++++
 tb/tb_ps2_byte_receiver.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_byte_receiver_if.sv
// PS/2 line inputs and scan-code byte outputs of the keyboard front end.
// master drives the PS/2 lines and consumes bytes; slave is the receiver.
interface ps2_byte_receiver_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] key_byte;
   logic       byte_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport master (
      output ps2_clk,
      output ps2_data,
      input  key_byte,
      input  byte_valid,
      input  parity_err,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output key_byte,
      output byte_valid,
      output parity_err,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/ps2_byte_receiver.sv
// PS/2 deserialiser: synchronises and glitch-filters the keyboard lines, then
// assembles start/8 data/odd parity/stop frames into scan-code bytes.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a start bit (fe with data = 0)
// ST_DATA   | collecting d0..d7, LSB first
// ST_PARITY | waiting for the odd-parity bit
// ST_STOP   | waiting for the stop bit; frame is judged on its fe
module ps2_byte_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                clk,
   input  logic                rst_n,
   ps2_byte_receiver_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int FLT_W = $clog2(FILTER_LEN + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   s_clk;
   logic                   s_data;

   logic [FLT_W-1:0]       filt_cnt;
   logic                   filt_clk;
   logic                   filt_clk_d;
   logic                   fe;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [2:0]             bit_cnt;
   logic [2:0]             bit_cnt_nxt;
   logic [7:0]             shift_reg;
   logic [7:0]             shift_nxt;
   logic                   par_bit;
   logic                   par_nxt;
   logic [TMO_W-1:0]       tmo_cnt;
   logic [TMO_W-1:0]       tmo_nxt;

   logic [7:0]             key_byte_q;
   logic [7:0]             key_nxt;
   logic                   byte_valid_q;
   logic                   byte_valid_nxt;
   logic                   parity_err_q;
   logic                   parity_err_nxt;
   logic                   frame_err_q;
   logic                   frame_err_nxt;
   logic                   busy_q;

   // -------------------------------------------------------------------
   // Input synchronisers
   // -------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      end
   end

   assign s_clk  = clk_sync[SYNC_STAGES-1];
   assign s_data = data_sync[SYNC_STAGES-1];

   // -------------------------------------------------------------------
   // Clock glitch filter: filt_cnt counts consecutive samples that disagree
   // with the current filtered level; any agreeing sample restarts it.
   // -------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt   <= '0;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
      end else begin
         filt_clk_d <= filt_clk;
         if (s_clk == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FLT_LAST) begin
            filt_clk <= s_clk;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FLT_W'(1);
         end
      end
   end

   assign fe = filt_clk_d & ~filt_clk;

   // -------------------------------------------------------------------
   // Frame state machine
   // -------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      shift_nxt      = shift_reg;
      par_nxt        = par_bit;
      tmo_nxt        = tmo_cnt;
      key_nxt        = key_byte_q;
      byte_valid_nxt = 1'b0;
      parity_err_nxt = 1'b0;
      frame_err_nxt  = 1'b0;

      if (state == ST_IDLE) begin
         tmo_nxt = '0;
         if (fe && !s_data) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = 3'd0;
            tmo_nxt     = TMO_LOAD;
         end
      end else if (fe) begin
         tmo_nxt = TMO_LOAD;
         case (state)
            ST_DATA: begin
               shift_nxt[bit_cnt] = s_data;
               if (bit_cnt == 3'd7) begin
                  state_nxt = ST_PARITY;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
            ST_PARITY: begin
               par_nxt   = s_data;
               state_nxt = ST_STOP;
            end
            default: begin
               state_nxt = ST_IDLE;
               tmo_nxt   = '0;
               if (!s_data) begin
                  frame_err_nxt = 1'b1;
               end else if (!(^{shift_reg, par_bit})) begin
                  parity_err_nxt = 1'b1;
               end else begin
                  key_nxt        = shift_reg;
                  byte_valid_nxt = 1'b1;
               end
            end
         endcase
      end else if (tmo_cnt == '0) begin
         // Down-counter reached terminal count with no fe: abandon the frame.
         state_nxt     = ST_IDLE;
         bit_cnt_nxt   = 3'd0;
         shift_nxt     = '0;
         par_nxt       = 1'b0;
         frame_err_nxt = 1'b1;
      end else begin
         tmo_nxt = tmo_cnt - TMO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= 3'd0;
         shift_reg    <= 8'h00;
         par_bit      <= 1'b0;
         tmo_cnt      <= '0;
         key_byte_q   <= 8'h00;
         byte_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         bit_cnt      <= bit_cnt_nxt;
         shift_reg    <= shift_nxt;
         par_bit      <= par_nxt;
         tmo_cnt      <= tmo_nxt;
         key_byte_q   <= key_nxt;
         byte_valid_q <= byte_valid_nxt;
         parity_err_q <= parity_err_nxt;
         frame_err_q  <= frame_err_nxt;
         busy_q       <= (state_nxt != ST_IDLE);
      end
   end

   assign bus.key_byte   = key_byte_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Bench for ps2_byte_receiver: directed frame table, hand-built corner cases
// and random frames judged by a parity/stop-bit reference model.
module tb_ps2_byte_receiver;

   localparam int HALF = 40;
   localparam int TMO  = 1000;
   localparam int K_VALID = 1;
   localparam int K_PAR   = 2;
   localparam int K_FRAME = 3;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         kind;
      logic [7:0] key;
   } vec_t;

   typedef struct {
      int         kind;
      logic [7:0] val;
      int         cyc;
      int         nhot;
   } ev_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   last_fall;
   int   ev_base;
   ev_t  ev_q[$];
   vec_t vecs[6];

   ps2_byte_receiver_if bus ();

   ps2_byte_receiver #(
      .SYNC_STAGES   (2),
      .FILTER_LEN    (4),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every status pulse with the key_byte value and cycle it came with.
   always @(negedge clk) begin
      if (rst_n && (bus.byte_valid || bus.parity_err || bus.frame_err)) begin
         ev_q.push_back('{bus.byte_valid ? K_VALID : (bus.parity_err ? K_PAR : K_FRAME),
                          bus.key_byte, cyc,
                          $countones({bus.byte_valid, bus.parity_err, bus.frame_err})});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      tick(HALF / 2);
      bus.ps2_data = b;
      tick(HALF / 2);
      bus.ps2_clk = 1'b0;
      last_fall = cyc;
      tick(HALF);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      ev_base = ev_q.size();
      for (int i = 0; i < 11; i++) begin
         send_bit(bits[i]);
         if (i == 3) chk("busy mid-frame", 32'(bus.busy), 32'd1);
      end
      bus.ps2_data = 1'b1;
      tick(10);
   endtask

   task automatic expect_one(input string name, input int kind, input logic [7:0] key);
      int n;
      n = ev_q.size() - ev_base;
      chk({name, " pulse count"}, 32'(n), 32'd1);
      if (n >= 1) begin
         chk({name, " pulse kind"}, 32'(ev_q[ev_base].kind), 32'(kind));
         chk({name, " exclusive"}, 32'(ev_q[ev_base].nhot), 32'd1);
         chk({name, " key at pulse"}, 32'(ev_q[ev_base].val), 32'(key));
      end
      chk({name, " key_byte"}, 32'(bus.key_byte), 32'(key));
      chk({name, " busy after"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic expect_none(input string name);
      chk({name, " no pulse"}, 32'(ev_q.size() - ev_base), 32'd0);
      chk({name, " busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      logic       p;
      logic       s;
      int         e;
      int         exp_kind;
      logic [7:0] model_key;
      int         n;

      n_tests = 0;
      n_fail  = 0;
      ev_base = 0;
      last_fall = 0;

      vecs[0] = '{8'h24, 1'b0, 1'b1, K_PAR,   8'h00};
      vecs[1] = '{8'h1D, 1'b1, 1'b1, K_VALID, 8'h1D};
      vecs[2] = '{8'hF0, 1'b1, 1'b1, K_VALID, 8'hF0};
      vecs[3] = '{8'h1D, 1'b1, 1'b1, K_VALID, 8'h1D};
      vecs[4] = '{8'h2D, 1'b1, 1'b0, K_FRAME, 8'h1D};
      vecs[5] = '{8'h2D, 1'b1, 1'b1, K_VALID, 8'h2D};

      rst_n = 1'b0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      tick(3);
      chk("reset key_byte", 32'(bus.key_byte), 32'h0);
      chk("reset byte_valid", 32'(bus.byte_valid), 32'h0);
      chk("reset parity_err", 32'(bus.parity_err), 32'h0);
      chk("reset frame_err", 32'(bus.frame_err), 32'h0);
      chk("reset busy", 32'(bus.busy), 32'h0);
      rst_n = 1'b1;
      tick(10);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
         expect_one($sformatf("vec%0d", i), vecs[i].kind, vecs[i].key);
      end

      // Timeout: start + 4 data bits, then the clock stays high.
      ev_base = ev_q.size();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      bus.ps2_data = 1'b1;
      chk("timeout busy before", 32'(bus.busy), 32'd1);
      for (int k = 0; k < TMO + 100; k++) begin
         if (ev_q.size() > ev_base) break;
         tick(1);
      end
      n = ev_q.size() - ev_base;
      chk("timeout pulse seen", 32'(n > 0), 32'd1);
      if (n > 0) begin
         chk("timeout kind", 32'(ev_q[ev_base].kind), 32'(K_FRAME));
         chk("timeout delay in window",
             32'((ev_q[ev_base].cyc - last_fall >= TMO + 4) &&
                 (ev_q[ev_base].cyc - last_fall <= TMO + 12)), 32'd1);
      end
      tick(2);
      chk("timeout busy after", 32'(bus.busy), 32'd0);
      chk("timeout key kept", 32'(bus.key_byte), 32'h2D);
      send_frame(8'h2D, 1'b1, 1'b1);
      expect_one("after timeout", K_VALID, 8'h2D);

      // Two-cycle clock glitch while idle, then an fe with data high.
      ev_base = ev_q.size();
      tick(5);
      bus.ps2_clk = 1'b0;
      tick(2);
      bus.ps2_clk = 1'b1;
      tick(20);
      expect_none("glitch");
      send_bit(1'b1);
      tick(20);
      expect_none("idle fe data high");

      // Reset mid-frame.
      ev_base = ev_q.size();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      chk("pre-reset busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid reset key_byte", 32'(bus.key_byte), 32'h0);
      chk("mid reset busy", 32'(bus.busy), 32'h0);
      chk("mid reset pulses",
          32'({bus.byte_valid, bus.parity_err, bus.frame_err}), 32'h0);
      bus.ps2_data = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(10);
      chk("reset no pulse", 32'(ev_q.size() - ev_base), 32'd0);
      send_frame(8'h1C, 1'b0, 1'b1);
      expect_one("after reset", K_VALID, 8'h1C);

      // Random frames against the parity/stop-bit reference model.
      model_key = 8'h1C;
      for (int i = 0; i < 30; i++) begin
         d = 8'($urandom);
         e = $urandom_range(0, 9);
         p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
         if (e == 8) p = ~p;
         s = (e == 9) ? 1'b0 : 1'b1;
         if (!s) begin
            exp_kind = K_FRAME;
         end else if ((($countones(d) + int'(p)) % 2) == 1) begin
            exp_kind  = K_VALID;
            model_key = d;
         end else begin
            exp_kind = K_PAR;
         end
         send_frame(d, p, s);
         expect_one($sformatf("rand%0d d=%0h p=%0d s=%0d", i, d, p, s), exp_kind, model_key);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
